// File: rtl/ddr5_cmd_sequencer_pkg.sv
// ddr5_cmd_sequencer_pkg: shared command/op encodings, default DDR5 timing and bank indexing.
package ddr5_cmd_sequencer_pkg;
  localparam int NUM_BG    = 8;
  localparam int NUM_BANK  = 4;
  localparam int NUM_BANKS = NUM_BG * NUM_BANK;
  localparam int ID_W      = 5;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 10;
  localparam int T_RCD     = 39;
  localparam int T_RP      = 39;
  localparam int T_RAS     = 76;
  localparam int T_CCD     = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT0, CMD_ACT1, CMD_RD0, CMD_RD1, CMD_WR0, CMD_WR1, CMD_PRE
  } cmd_t;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_IFETCH, OP_RSVD} req_op_t;

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_ACT0, ST_ACT1, ST_COL0, ST_COL1} state_t;

  function automatic logic [ID_W-1:0] bank_id(input logic [2:0] bg, input logic [1:0] bank);
    return ID_W'(int'(bg) * NUM_BANK + int'(bank));
  endfunction
endpackage

// File: rtl/ddr5_bank_state.sv
// ddr5_bank_state: one bank's open row plus its tRAS and ACT/column readiness timers.
module ddr5_bank_state
  import ddr5_cmd_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_act0,
  input  logic             i_act1,
  input  logic             i_pre,
  input  logic [ROW_W-1:0] i_row,
  output logic             o_hit,
  output logic             o_open,
  output logic             o_ras_ok,
  output logic             o_rdy_ok
);
  logic             r_open;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_ras;
  logic [CNT_W-1:0] r_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_open <= 1'b0;
      r_row  <= '0;
      r_ras  <= '0;
      r_rdy  <= '0;
    end else begin
      r_open <= i_act1 ? 1'b1 : i_pre ? 1'b0 : r_open;
      r_row  <= i_act1 ? i_row : r_row;
      r_ras  <= i_act0 ? CNT_W'(T_RAS - 1) : r_ras - CNT_W'(r_ras != '0);
      // rdy_cnt serves both PRE->ACT0 and ACT0->column spacing
      r_rdy  <= i_act0 ? CNT_W'(T_RCD - 1) : i_pre ? CNT_W'(T_RP - 1) : r_rdy - CNT_W'(r_rdy != '0);
    end
  end

  assign o_open   = r_open;
  assign o_hit    = r_open && (r_row == i_row);
  assign o_ras_ok = r_ras == '0;
  assign o_rdy_ok = r_rdy == '0;
endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// ddr5_cmd_sequencer: expands one queued request into a timed open-page DDR5 command stream.
module ddr5_cmd_sequencer
  import ddr5_cmd_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [2:0]       i_req_bg,
  input  logic [1:0]       i_req_bank,
  input  logic [ROW_W-1:0] i_req_row,
  input  logic [COL_W-1:0] i_req_col,
  output logic             o_cmd_valid,
  output logic [2:0]       o_cmd_code,
  output logic [2:0]       o_cmd_bg,
  output logic [1:0]       o_cmd_bank,
  output logic [ROW_W-1:0] o_cmd_row,
  output logic [COL_W-1:0] o_cmd_col,
  output logic             o_req_done
);
  state_t           r_state, w_tgt, w_succ, w_next;
  cmd_t             r_cmd_code, w_code;
  logic             r_ready, r_cmd_valid, r_done;
  logic [1:0]       r_op, r_bank, r_cmd_bank, w_op, w_bank;
  logic [2:0]       r_bg, r_cmd_bg, w_bg;
  logic [ROW_W-1:0] r_row, r_cmd_row, w_row;
  logic [COL_W-1:0] r_col, r_cmd_col, w_col;
  logic [CNT_W-1:0] r_ccd;
  logic [ID_W-1:0]  w_id;
  logic             w_acc, w_issue, w_wr;
  logic [NUM_BANKS-1:0] w_hit, w_open, w_ras_ok, w_rdy_ok, w_act0, w_act1, w_pre;

  assign w_acc  = i_req_valid && r_ready;
  // while ready the live request fields drive decisions so the first command can issue next cycle
  assign w_op   = r_ready ? i_req_op   : r_op;
  assign w_bg   = r_ready ? i_req_bg   : r_bg;
  assign w_bank = r_ready ? i_req_bank : r_bank;
  assign w_row  = r_ready ? i_req_row  : r_row;
  assign w_col  = r_ready ? i_req_col  : r_col;
  assign w_id   = bank_id(w_bg, w_bank);

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_act0[b] = w_issue && (w_tgt == ST_ACT0) && (w_id == ID_W'(b));
      assign w_act1[b] = w_issue && (w_tgt == ST_ACT1) && (w_id == ID_W'(b));
      assign w_pre[b]  = w_issue && (w_tgt == ST_PRE)  && (w_id == ID_W'(b));
      ddr5_bank_state u_bank (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_act0   (w_act0[b]),
        .i_act1   (w_act1[b]),
        .i_pre    (w_pre[b]),
        .i_row    (w_row),
        .o_hit    (w_hit[b]),
        .o_open   (w_open[b]),
        .o_ras_ok (w_ras_ok[b]),
        .o_rdy_ok (w_rdy_ok[b])
      );
    end
  endgenerate

  always_comb begin
    w_tgt   = (r_state != ST_IDLE) ? r_state : !w_acc ? ST_IDLE :
              !w_open[w_id] ? ST_ACT0 : w_hit[w_id] ? ST_COL0 : ST_PRE;
    w_wr    = req_op_t'(w_op) == OP_WR;
    w_issue = 1'b0;
    w_code  = CMD_NOP;
    w_succ  = ST_IDLE;
    case (w_tgt)
      ST_PRE:  begin w_issue = w_ras_ok[w_id]; w_code = CMD_PRE; w_succ = ST_ACT0; end
      ST_ACT0: begin w_issue = w_rdy_ok[w_id]; w_code = CMD_ACT0; w_succ = ST_ACT1; end
      ST_ACT1: begin w_issue = 1'b1; w_code = CMD_ACT1; w_succ = ST_COL0; end
      ST_COL0: begin w_issue = w_rdy_ok[w_id] && (r_ccd == '0); w_code = w_wr ? CMD_WR0 : CMD_RD0; w_succ = ST_COL1; end
      ST_COL1: begin w_issue = 1'b1; w_code = w_wr ? CMD_WR1 : CMD_RD1; w_succ = ST_IDLE; end
      default: ;
    endcase
    w_next  = w_issue ? w_succ : w_tgt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready     <= 1'b0;
      r_op        <= '0;
      r_bg        <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_ccd       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_NOP;
      r_cmd_bg    <= '0;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_done      <= 1'b0;
    end else begin
      // the cycle showing RD1/WR1 is not yet ready; readiness follows one cycle later
      r_ready     <= (w_next == ST_IDLE) && !(w_issue && w_tgt == ST_COL1);
      if (w_acc) begin
        r_op   <= i_req_op;
        r_bg   <= i_req_bg;
        r_bank <= i_req_bank;
        r_row  <= i_req_row;
        r_col  <= i_req_col;
      end
      r_ccd       <= (w_issue && w_tgt == ST_COL0) ? CNT_W'(T_CCD - 1) : r_ccd - CNT_W'(r_ccd != '0);
      r_cmd_valid <= w_issue;
      r_cmd_code  <= w_issue ? w_code : CMD_NOP;
      r_cmd_bg    <= w_issue ? w_bg : '0;
      r_cmd_bank  <= w_issue ? w_bank : '0;
      r_cmd_row   <= (w_issue && (w_tgt == ST_ACT0 || w_tgt == ST_ACT1)) ? w_row : '0;
      r_cmd_col   <= (w_issue && (w_tgt == ST_COL0 || w_tgt == ST_COL1)) ? w_col : '0;
      r_done      <= w_issue && (w_tgt == ST_COL1);
    end
  end

  assign o_req_ready = r_ready;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_code  = r_cmd_code;
  assign o_cmd_bg    = r_cmd_bg;
  assign o_cmd_bank  = r_cmd_bank;
  assign o_cmd_row   = r_cmd_row;
  assign o_cmd_col   = r_cmd_col;
  assign o_req_done  = r_done;
endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// tb_ddr5_cmd_sequencer: schedule-based reference model of the command stream, checked every cycle.
module tb_ddr5_cmd_sequencer;
  localparam int T_RCD = 39, T_RP = 39, T_RAS = 76, T_CCD = 8;
  localparam logic [2:0] C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3, C_RD1 = 3'd4,
                         C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [1:0]  op = '0, bk = '0;
  logic [2:0]  bg = '0;
  logic [15:0] row = '0;
  logic [9:0]  col = '0;
  logic        o_req_ready, o_cmd_valid, o_req_done;
  logic [2:0]  o_cmd_code, o_cmd_bg;
  logic [1:0]  o_cmd_bank;
  logic [15:0] o_cmd_row;
  logic [9:0]  o_cmd_col;

  always #5 clk = ~clk;

  ddr5_cmd_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (op),
    .i_req_bg    (bg),
    .i_req_bank  (bk),
    .i_req_row   (row),
    .i_req_col   (col),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd_code  (o_cmd_code),
    .o_cmd_bg    (o_cmd_bg),
    .o_cmd_bank  (o_cmd_bank),
    .o_cmd_row   (o_cmd_row),
    .o_cmd_col   (o_cmd_col),
    .o_req_done  (o_req_done)
  );

  typedef struct packed {
    logic [2:0]  code;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic        done;
  } ev_t;

  ev_t ev[int];
  int  cyc = 0, checks = 0, failures = 0, ready_at = 0, lcol = -1000;
  bit  in_rst = 1'b1;
  bit  open_m[32];
  int  row_m[32], lact[32], lpre[32];

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    ev.delete();
    for (int i = 0; i < 32; i++) begin
      open_m[i] = 1'b0;
      row_m[i]  = 0;
      lact[i]   = -1000;
      lpre[i]   = -1000;
    end
    lcol   = -1000;
    in_rst = 1'b1;
  endtask

  task automatic put(input int t, input logic [2:0] c, input logic [2:0] g, input logic [1:0] k,
                     input logic [15:0] rw, input logic [9:0] cl, input logic d);
    ev[t] = '{c, g, k, rw, cl, d};
  endtask

  task automatic model_req(input logic [1:0] o, input logic [2:0] g, input logic [1:0] k,
                           input logic [15:0] rw, input logic [9:0] cl);
    int  id, a, p, c;
    bit  wr;
    id = int'(g) * 4 + int'(k);
    wr = (o == 2'd1);
    if (open_m[id] && row_m[id] == int'(rw)) begin
      c = mx(mx(cyc + 1, lact[id] + T_RCD), lcol + T_CCD);
    end else begin
      if (open_m[id]) begin
        p = mx(cyc + 1, lact[id] + T_RAS);
        put(p, C_PRE, g, k, 16'h0, 10'h0, 1'b0);
        lpre[id] = p;
        a = p + T_RP;
      end else begin
        a = mx(cyc + 1, lpre[id] + T_RP);
      end
      put(a, C_ACT0, g, k, rw, 10'h0, 1'b0);
      put(a + 1, C_ACT1, g, k, rw, 10'h0, 1'b0);
      lact[id]   = a;
      open_m[id] = 1'b1;
      row_m[id]  = int'(rw);
      c = mx(a + T_RCD, lcol + T_CCD);
    end
    put(c, wr ? C_WR0 : C_RD0, g, k, 16'h0, cl, 1'b0);
    put(c + 1, wr ? C_WR1 : C_RD1, g, k, 16'h0, cl, 1'b1);
    lcol     = c;
    ready_at = c + 2;
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", n, cyc, a, x);
    end
  endtask

  task automatic check();
    ev_t         e;
    logic [36:0] got, want;
    e = '0;
    if (ev.exists(cyc)) e = ev[cyc];
    got  = {o_cmd_valid, o_cmd_code, o_cmd_bg, o_cmd_bank, o_cmd_row, o_cmd_col, o_req_done, o_req_ready};
    want = {e.code != 3'd0, e, !in_rst && cyc >= ready_at};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL stream cycle=%0d got=%h want=%h", cyc, got, want);
    end
    case (cyc)
      1:   lit("reset_state", 32'({o_cmd_valid, o_cmd_code, o_cmd_bg, o_cmd_bank, o_req_done, o_req_ready, o_cmd_row}), 32'h0);
      3:   lit("ready_after_reset", 32'(o_req_ready), 32'h1);
      11:  lit("act0_closed", 32'({o_cmd_code, o_cmd_bg, o_cmd_bank}), 32'({C_ACT0, 3'd2, 2'd1}));
      12:  lit("act1_row", 32'({o_cmd_code, o_cmd_row}), 32'({C_ACT1, 16'h1A2B}));
      50:  lit("rd0_trcd", 32'({o_cmd_code, o_cmd_col}), 32'({C_RD0, 10'h040}));
      51:  lit("rd1_done", 32'({o_cmd_code, o_req_done}), 32'({C_RD1, 1'b1}));
      52:  lit("ready_after_rd1", 32'(o_req_ready), 32'h1);
      58:  lit("hit_rd0_tccd", 32'({o_cmd_code, o_cmd_col}), 32'({C_RD0, 10'h048}));
      59:  lit("hit_rd1_done", 32'({o_cmd_code, o_req_done}), 32'({C_RD1, 1'b1}));
      87:  lit("miss_pre_tras", 32'({o_cmd_code, o_cmd_bg, o_cmd_bank}), 32'({C_PRE, 3'd2, 2'd1}));
      126: lit("miss_act0_trp", 32'({o_cmd_code, o_cmd_row}), 32'({C_ACT0, 16'h0001}));
      165: lit("miss_wr0", 32'({o_cmd_code, o_cmd_col}), 32'({C_WR0, 10'h2C0}));
      166: lit("miss_wr1_done", 32'({o_cmd_code, o_req_done}), 32'({C_WR1, 1'b1}));
      168: lit("indep_act0", 32'({o_cmd_code, o_cmd_bg, o_cmd_bank}), 32'({C_ACT0, 3'd3, 2'd0}));
      207: lit("indep_rd0", 32'({o_cmd_code, o_cmd_col}), 32'({C_RD0, 10'h011}));
      215: lit("backpressure_fields", 32'({o_cmd_code, o_cmd_col}), 32'({C_RD0, 10'h100}));
      226: lit("act0_after_reset", 32'({o_cmd_code, o_cmd_bg, o_cmd_bank}), 32'({C_ACT0, 3'd5, 2'd2}));
      default: ;
    endcase
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] o, input logic [2:0] g,
                      input logic [1:0] k, input logic [15:0] rw, input logic [9:0] c);
    @(negedge clk);
    check();
    if (rst_n && !r) begin
      rst_n = 1'b0;
      #1;
      lit("async_reset", 32'({o_cmd_valid, o_cmd_code, o_req_done, o_req_ready, o_cmd_row}), 32'h0);
      model_reset();
    end else if (!rst_n && r) begin
      rst_n    = 1'b1;
      in_rst   = 1'b0;
      ready_at = cyc + 1;
    end
    valid = v; op = o; bg = g; bk = k; row = rw; col = c;
    if (v && !in_rst && cyc >= ready_at) model_req(o, g, k, rw, c);
    cyc++;
  endtask

  task automatic idle_to(input int t);
    while (cyc < t) step(1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 16'h0, 10'h0);
  endtask

  task automatic rnd_step(input bit r, input bit v);
    step(r, v, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
         16'($urandom_range(0, 2)), 10'($urandom_range(0, 1023)));
  endtask

  initial begin
    model_reset();
    step(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 16'h0, 10'h0);
    step(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 16'h0, 10'h0);
    idle_to(10);
    step(1'b1, 1'b1, 2'd0, 3'd2, 2'd1, 16'h1A2B, 10'h040);
    idle_to(52);
    step(1'b1, 1'b1, 2'd0, 3'd2, 2'd1, 16'h1A2B, 10'h048);
    idle_to(60);
    step(1'b1, 1'b1, 2'd1, 3'd2, 2'd1, 16'h0001, 10'h2C0);
    idle_to(167);
    step(1'b1, 1'b1, 2'd0, 3'd3, 2'd0, 16'h0BEE, 10'h011);
    while (cyc < 209) rnd_step(1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd0, 3'd2, 2'd1, 16'h0001, 10'h100);
    idle_to(217);
    step(1'b1, 1'b1, 2'd0, 3'd5, 2'd2, 16'h55AA, 10'h003);
    idle_to(219);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 16'h0, 10'h0);
    idle_to(225);
    step(1'b1, 1'b1, 2'd0, 3'd5, 2'd2, 16'h55AA, 10'h003);
    while (cyc < 15000) rnd_step(($urandom_range(0, 4999) != 0) || !rst_n, $urandom_range(0, 3) != 0);
    idle_to(15300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
